bridge_tx: RTL and testbench
============================

Name: bridge_tx

Overview:
- Terminal stage of the memory-core daisy chain; consumes the bus outputs of the last core (addr/wdata/rdata/rw/valid).
- Turns each completed read into an ASCII hex response line for the UART transmitter.
- Pairs with bridge_rx, which issues requests at the head of the chain.
- The chain has no backpressure, so this block absorbs burstiness with a one-entry pending buffer and flags any dropped response.

Parameters:
- DATA_WIDTH, 16, bus data width; must be a multiple of 4. Hex digits per response N = DATA_WIDTH/4.
- ADDR_WIDTH, 16, bus address width. Accepted on the input but not used in the response.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr_i  input  ADDR_WIDTH  bus address from the last core; ignored.
- wdata_i  input  DATA_WIDTH  bus write data; ignored.
- rdata_i  input  DATA_WIDTH  read data returned by the chain.
- rw_i  input  1  1 = write, 0 = read.
- valid_i  input  1  single-cycle bus transaction strobe.
- uart_data_o  output  8  byte to the UART transmitter.
- uart_valid_o  output  1  uart_data_o is valid.
- uart_ready_i  input  1  transmitter accepts the byte this cycle.
- busy_o  output  1  a message is active or pending.
- overflow_o  output  1  sticky: a response was dropped.

Behaviour:
- Reset (async assert, held until release): every output is 0, state IDLE, pending buffer empty, overflow_o cleared.
- Message format: 'M' (0x4D), then N uppercase hex digits MSB first ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46), then 0x0D, then 0x0A. L = N+3 bytes (7 when DATA_WIDTH=16).
- Capture: valid_i && !rw_i is a read response. Write transactions (rw_i=1) produce nothing.
- Handshake: a byte transfers on a clock edge where uart_valid_o && uart_ready_i.
  - While uart_ready_i is low, uart_data_o and uart_valid_o hold.
  - uart_valid_o never drops mid-message.
- State machine IDLE / SEND with byte index idx in 0..L-1:
  - IDLE, read captured at edge N: load the active register, idx=0, go to SEND. uart_valid_o=1 with 'M' from cycle N+1 (1-cycle latency).
  - SEND: idx increments on each handshake.
  - On the handshake of idx=L-1: if pending is valid, move it into active, clear pending, idx=0, stay in SEND with no idle bubble. Otherwise go to IDLE with uart_valid_o=0 next cycle.
- Pending buffer (depth 1): a read arriving in SEND is stored in pending if it is empty.
- Drop: if pending is full, the new read is discarded and overflow_o is set; it stays set until reset.
- Simultaneous events:
  - Read arrives on the last-byte handshake edge with pending empty: it loads directly into active and is not dropped.
  - Same case with pending full: pending moves into active, the new read goes into pending, and there is no drop.
- busy_o = (state==SEND) || pending valid, registered.
- Reset mid-message: the message is abandoned with no partial completion; the next read starts cleanly with 'M'.

Optional Feature:
- Macro: BRIDGE_TX_WRITE_ACK_EN.
- Defined: a write (valid_i && rw_i) produces the 3-byte ack "W\r\n" (0x57 0x0D 0x0A).
  - Acks share the active/pending path and the overflow rules with reads.
  - The active register carries a kind bit that selects message length and bytes.
- Undefined: writes are ignored entirely, and the kind bit and ack logic are absent.

Decomposition:
- Package bridge_pkg holds:
  - ASCII constants (CHAR_M, CHAR_W, CHAR_CR, CHAR_LF);
  - the state enum (IDLE, SEND);
  - function hex_to_ascii(logic [3:0]) returning logic [7:0].
- One sub-module is natural: bridge_tx_byte_sel.
  - Combinational selection of uart_data_o from the active word, idx and kind.
  - Keeps the sequencing FSM in bridge_tx small.

Test Plan:
- Read, rdata_i=16'h0012, uart_ready_i=1 → exactly 0x4D 0x30 0x30 0x31 0x32 0x0D 0x0A on consecutive cycles, starting 1 cycle after valid_i. busy_o then drops and overflow_o=0.
- Write to 0x0012 with wdata 0x0069 → no uart_valid_o without the macro; with BRIDGE_TX_WRITE_ACK_EN → 0x57 0x0D 0x0A.
- Read 16'hBEEF, uart_ready_i low for 5 cycles after the 3rd byte → the 'E' (0x45) byte is held stable for all 5 cycles. Full stream is 0x4D 0x42 0x45 0x45 0x46 0x0D 0x0A.
- Back-to-back reads 16'h000A then 16'h0017 one cycle apart → two complete messages, "M000A\r\n" then "M0017\r\n", with no idle cycle between them and overflow_o=0.
- Three reads 16'h0001, 16'h0002, 16'h0003 on consecutive cycles → "M0001" and "M0002" lines are sent, 0x0003 is dropped, and overflow_o=1 stays latched.
- Assert rst during byte 3 of "M0010" → all outputs 0 asynchronously. After release, read 16'h0011 → a clean "M0011\r\n" and overflow_o=0.

Source files
------------

// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the bridge_tx response path.
//   CHAR_*        ASCII bytes used to frame response lines
//   state_e       sequencing states of the transmit FSM
//   hex_to_ascii  one nibble -> uppercase ASCII hex digit
// ---------------------------------------------------------------------------
package bridge_pkg;

    localparam logic [7:0] CHAR_M  = 8'h4D;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // 0-9 map onto 0x30.., A-F onto 0x41.. (0x37 + 10 = 0x41).
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/bridge_tx_byte_sel.sv
// ---------------------------------------------------------------------------
// bridge_tx_byte_sel
// Combinational byte selector for one response line.
// Read line : 'M', N hex digits MSB first, CR, LF (N = DATA_WIDTH/4).
// Ack line  : 'W', CR, LF (only when BRIDGE_TX_WRITE_ACK_EN is defined).
// Ports:
//   i_data  active data word
//   i_idx   byte index within the line
//   i_kind  1 = write ack, 0 = read response (BRIDGE_TX_WRITE_ACK_EN only)
//   o_byte  selected ASCII byte (0 for out-of-range index)
// ---------------------------------------------------------------------------
module bridge_tx_byte_sel
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 3
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [IDX_W-1:0]      i_idx,
`ifdef BRIDGE_TX_WRITE_ACK_EN
    input  logic                  i_kind,
`endif
    output logic [7:0]            o_byte
);

    localparam int N = DATA_WIDTH / 4;

    logic [7:0] w_digit [N];

    // w_digit[0] is the most significant nibble, sent first.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digit
            assign w_digit[gi] = hex_to_ascii(i_data[DATA_WIDTH-1-4*gi -: 4]);
        end
    endgenerate

    always_comb begin
        o_byte = 8'h00;
        if (i_idx == '0) begin
            o_byte = CHAR_M;
        end
        for (int k = 0; k < N; k++) begin
            if (i_idx == IDX_W'(k + 1)) begin
                o_byte = w_digit[k];
            end
        end
        if (i_idx == IDX_W'(N + 1)) begin
            o_byte = CHAR_CR;
        end
        if (i_idx == IDX_W'(N + 2)) begin
            o_byte = CHAR_LF;
        end
`ifdef BRIDGE_TX_WRITE_ACK_EN
        if (i_kind) begin
            case (i_idx)
                IDX_W'(0): o_byte = CHAR_W;
                IDX_W'(1): o_byte = CHAR_CR;
                IDX_W'(2): o_byte = CHAR_LF;
                default:   o_byte = 8'h00;
            endcase
        end
`endif
    end

endmodule

// File: rtl/bridge_tx.sv
// ---------------------------------------------------------------------------
// bridge_tx
// Tail of the memory-core chain: each completed read becomes an ASCII hex
// line "M<hex>\r\n" streamed to a UART transmitter. The chain cannot be
// stalled, so one pending entry absorbs a burst; a response arriving while
// the pending entry is occupied is dropped and overflow_o latches.
// Optional macro BRIDGE_TX_WRITE_ACK_EN: writes produce "W\r\n" through the
// same active/pending path.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   addr_i, wdata_i      bus address / write data (not used in responses)
//   rdata_i, rw_i        read data, 1 = write / 0 = read
//   valid_i              single-cycle transaction strobe
//   uart_data_o          byte to transmitter (0 when not valid)
//   uart_valid_o         byte valid; handshake with uart_ready_i
//   busy_o               line in progress or pending (registered)
//   overflow_o           sticky response-dropped flag
// ---------------------------------------------------------------------------
module bridge_tx
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [7:0]            uart_data_o,
    output logic                  uart_valid_o,
    input  logic                  uart_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int N     = DATA_WIDTH / 4;
    localparam int L_RD  = N + 3;
    localparam int IDX_W = $clog2(L_RD);
    localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(L_RD - 1);

    state_e                r_state,      w_state_next;
    logic [IDX_W-1:0]      r_idx,        w_idx_next;
    logic [DATA_WIDTH-1:0] r_act_data,   w_act_data_next;
    logic                  r_pend_valid, w_pend_valid_next;
    logic [DATA_WIDTH-1:0] r_pend_data,  w_pend_data_next;
    logic                  r_overflow,   w_overflow_next;
    logic                  r_busy;

    logic                  w_cap;
    logic                  w_valid;
    logic                  w_hs;
    logic                  w_last;
    logic [7:0]            w_byte;
    logic                  w_unused_bus;

    // Address and write data never appear in a response line.
    assign w_unused_bus = ^{addr_i, wdata_i};

`ifdef BRIDGE_TX_WRITE_ACK_EN
    localparam logic [IDX_W-1:0] LAST_ACK = IDX_W'(2);
    logic r_act_kind,  w_act_kind_next;
    logic r_pend_kind, w_pend_kind_next;

    assign w_cap  = valid_i;
    assign w_last = (r_idx == (r_act_kind ? LAST_ACK : LAST_RD));
`else
    assign w_cap  = valid_i && !rw_i;
    assign w_last = (r_idx == LAST_RD);
`endif

    assign w_valid = (r_state == SEND);
    assign w_hs    = w_valid && uart_ready_i;

    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_act_data_next   = r_act_data;
        w_pend_valid_next = r_pend_valid;
        w_pend_data_next  = r_pend_data;
        w_overflow_next   = r_overflow;
`ifdef BRIDGE_TX_WRITE_ACK_EN
        w_act_kind_next   = r_act_kind;
        w_pend_kind_next  = r_pend_kind;
`endif
        case (r_state)
            IDLE: begin
                // Pending is always empty here, so a capture goes straight to active.
                if (w_cap) begin
                    w_state_next    = SEND;
                    w_idx_next      = '0;
                    w_act_data_next = rdata_i;
`ifdef BRIDGE_TX_WRITE_ACK_EN
                    w_act_kind_next = rw_i;
`endif
                end
            end
            SEND: begin
                if (w_hs && w_last) begin
                    w_idx_next = '0;
                    if (r_pend_valid) begin
                        // Pending becomes active; a same-edge capture refills
                        // pending, so nothing is lost on this edge.
                        w_act_data_next   = r_pend_data;
                        w_pend_valid_next = w_cap;
                        if (w_cap) begin
                            w_pend_data_next = rdata_i;
                        end
`ifdef BRIDGE_TX_WRITE_ACK_EN
                        w_act_kind_next = r_pend_kind;
                        if (w_cap) begin
                            w_pend_kind_next = rw_i;
                        end
`endif
                    end else if (w_cap) begin
                        w_act_data_next = rdata_i;
`ifdef BRIDGE_TX_WRITE_ACK_EN
                        w_act_kind_next = rw_i;
`endif
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                    if (w_cap) begin
                        if (!r_pend_valid) begin
                            w_pend_valid_next = 1'b1;
                            w_pend_data_next  = rdata_i;
`ifdef BRIDGE_TX_WRITE_ACK_EN
                            w_pend_kind_next  = rw_i;
`endif
                        end else begin
                            w_overflow_next = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
`ifdef BRIDGE_TX_WRITE_ACK_EN
            r_act_kind   <= 1'b0;
            r_pend_kind  <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_act_data   <= w_act_data_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_data  <= w_pend_data_next;
            r_overflow   <= w_overflow_next;
            r_busy       <= (w_state_next == SEND) || w_pend_valid_next;
`ifdef BRIDGE_TX_WRITE_ACK_EN
            r_act_kind   <= w_act_kind_next;
            r_pend_kind  <= w_pend_kind_next;
`endif
        end
    end

    bridge_tx_byte_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_byte_sel (
        .i_data (r_act_data),
        .i_idx  (r_idx),
`ifdef BRIDGE_TX_WRITE_ACK_EN
        .i_kind (r_act_kind),
`endif
        .o_byte (w_byte)
    );

    // Data is forced to 0 outside a message so reset/idle outputs are all 0.
    assign uart_data_o  = w_valid ? w_byte : 8'h00;
    assign uart_valid_o = w_valid;
    assign busy_o       = r_busy;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_bridge_tx.sv
module tb_bridge_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr_i = '0;
    logic [15:0] wdata_i = '0;
    logic [15:0] rdata_i = '0;
    logic        rw_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [7:0]  uart_data_o;
    logic        uart_valid_o;
    logic        uart_ready_i = 1'b1;
    logic        busy_o;
    logic        overflow_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] q_bytes [$];
    int         q_cyc   [$];
    logic [7:0] exp_q   [$];

    bridge_tx #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_i      (rdata_i),
        .rw_i         (rw_i),
        .valid_i      (valid_i),
        .uart_data_o  (uart_data_o),
        .uart_valid_o (uart_valid_o),
        .uart_ready_i (uart_ready_i),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 ns after the rising edge, so at the falling edge the
    // handshake condition is exactly what the next rising edge will see.
    always @(negedge clk) begin
        if (!rst && uart_valid_o && uart_ready_i) begin
            q_bytes.push_back(uart_data_o);
            q_cyc.push_back(cyc);
            $display("tx byte 0x%02h at cycle %0d", uart_data_o, cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] d, output int c0);
        c0      = cyc;
        valid_i = 1'b1;
        rw_i    = 1'b0;
        rdata_i = d;
        step();
        valid_i = 1'b0;
        $display("bus read  data=0x%04h at cycle %0d", d, c0);
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy_o || uart_valid_o) && k < 64) begin
            step();
            k++;
        end
        chk({tag, "_done"}, 32'(k < 64), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int first_cyc, input bit contig);
        chk({tag, "_len"}, q_bytes.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < q_bytes.size()) begin
                chk($sformatf("%s_b%0d", tag, i), q_bytes[i], exp_q[i]);
                if (contig || i == 0)
                    chk($sformatf("%s_c%0d", tag, i), q_cyc[i], first_cyc + i);
            end
        end
        q_bytes.delete();
        q_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int c0, c1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", uart_valid_o, 0);
        chk("rst_data", uart_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", overflow_o, 0);
        step();
        rst = 1'b0;
        step();

        // Single read 0x0012
        bus_read(16'h0012, c0);
        wait_idle("rd12");
        push_line("M0012");
        check_stream("rd12", c0 + 1, 1'b1);
        chk("rd12_busy", busy_o, 0);
        chk("rd12_ovf", overflow_o, 0);

        // Write transaction
        valid_i = 1'b1; rw_i = 1'b1; addr_i = 16'h0012; wdata_i = 16'h0069;
        c0 = cyc;
        step();
        valid_i = 1'b0; rw_i = 1'b0;
        $display("bus write addr=0x0012 data=0x0069 at cycle %0d", c0);
        repeat (10) step();
`ifdef BRIDGE_TX_WRITE_ACK_EN
        push_line("W");
`endif
        check_stream("wr", c0 + 1, 1'b1);
        chk("wr_busy", busy_o, 0);

        // Read 0xBEEF with a 5-cycle stall on the 4th byte
        bus_read(16'hBEEF, c0);
        repeat (3) step();
        uart_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("hold_data%0d", i), uart_data_o, 8'h45);
            chk($sformatf("hold_valid%0d", i), uart_valid_o, 1);
            step();
        end
        uart_ready_i = 1'b1;
        wait_idle("beef");
        push_line("MBEEF");
        check_stream("beef", c0 + 1, 1'b0);

        // Back-to-back reads one cycle apart
        bus_read(16'h000A, c0);
        bus_read(16'h0017, c1);
        wait_idle("b2b");
        push_line("M000A");
        push_line("M0017");
        check_stream("b2b", c0 + 1, 1'b1);
        chk("b2b_ovf", overflow_o, 0);

        // Read arriving exactly on the last-byte handshake of the previous line
        bus_read(16'h0001, c0);
        repeat (6) step();
        bus_read(16'h00C3, c1);
        wait_idle("edge");
        push_line("M0001");
        push_line("M00C3");
        check_stream("edge", c0 + 1, 1'b1);
        chk("edge_ovf", overflow_o, 0);

        // Three consecutive reads: third is dropped
        bus_read(16'h0001, c0);
        bus_read(16'h0002, c1);
        bus_read(16'h0003, c1);
        wait_idle("drop");
        push_line("M0001");
        push_line("M0002");
        check_stream("drop", c0 + 1, 1'b1);
        chk("drop_ovf", overflow_o, 1);
        repeat (5) step();
        chk("drop_ovf_sticky", overflow_o, 1);

        // Reset during the third byte of "M0010"
        bus_read(16'h0010, c0);
        repeat (2) step();
        chk("pre_rst_byte", uart_data_o, 8'h30);
        rst = 1'b1;
        #2;
        chk("arst_valid", uart_valid_o, 0);
        chk("arst_data", uart_data_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_ovf", overflow_o, 0);
        repeat (2) step();
        rst = 1'b0;
        q_bytes.delete();
        q_cyc.delete();
        step();
        bus_read(16'h0011, c0);
        wait_idle("post");
        push_line("M0011");
        check_stream("post", c0 + 1, 1'b1);
        chk("post_ovf", overflow_o, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
